// File: rtl/buffer_result_display.sv
// Hit statistics for the associative buffer's lookup result.
// Shows the latest hit data and a saturating hit count on four active-low 7-segment digits.
module buffer_result_display #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned BLINK_CYCLES = 25_000_000
) (
  input  logic                  clk,
  input  logic                  async_reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid_in,
  input  logic                  clear_stats,
  output logic [7:0]            hit_count,
  output logic [6:0]            hex0,
  output logic [6:0]            hex1,
  output logic [6:0]            hex2,
  output logic [6:0]            hex3,
  output logic [3:0]            hex_dp
);

  localparam int unsigned TimerWidth = $clog2(BLINK_CYCLES + 1);
  localparam logic [TimerWidth-1:0] BlinkLoad = TimerWidth'(BLINK_CYCLES);
  localparam logic [TimerWidth-1:0] TimerOne  = TimerWidth'(1);
  localparam logic [6:0] GlyphZero = 7'b1000000;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] seg;
    unique case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = GlyphZero;
    endcase
    return seg;
  endfunction

  logic                  valid_q;
  logic                  hit_event;
  logic [7:0]            count_q, count_d;
  logic [7:0]            held_q, held_d;
  logic [TimerWidth-1:0] timer_q, timer_d;
  logic [6:0]            hex0_q, hex1_q, hex2_q, hex3_q;
  logic [3:0]            dp_q;

  // Count rising edges of valid so a key that keeps hitting counts once.
  assign hit_event = data_valid_in & ~valid_q;

  always_comb begin
    count_d = count_q;
    held_d  = held_q;
    timer_d = timer_q;
    if (timer_q != '0) timer_d = timer_q - TimerOne;
    if (clear_stats) begin
      count_d = '0;
      held_d  = '0;
      timer_d = '0;
    end else begin
      if (hit_event) begin
        if (count_q != 8'hFF) count_d = count_q + 8'd1;
        timer_d = BlinkLoad;
      end
      if (data_valid_in) held_d = data_in[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!async_reset) begin
      valid_q <= 1'b0;
      count_q <= '0;
      held_q  <= '0;
      timer_q <= '0;
      hex0_q  <= GlyphZero;
      hex1_q  <= GlyphZero;
      hex2_q  <= GlyphZero;
      hex3_q  <= GlyphZero;
      dp_q    <= 4'b1111;
    end else begin
      // valid_q tracks the input even during clear so a held level is not recounted.
      valid_q <= data_valid_in;
      count_q <= count_d;
      held_q  <= held_d;
      timer_q <= timer_d;
      hex0_q  <= seg7(held_q[3:0]);
      hex1_q  <= seg7(held_q[7:4]);
      hex2_q  <= seg7(count_q[3:0]);
      hex3_q  <= seg7(count_q[7:4]);
      dp_q    <= {3'b111, (timer_q == '0)};
    end
  end

  assign hit_count = count_q;
  assign hex0      = hex0_q;
  assign hex1      = hex1_q;
  assign hex2      = hex2_q;
  assign hex3      = hex3_q;
  assign hex_dp    = dp_q;

endmodule

// File: doc/buffer_result_display.md
# buffer_result_display

Downstream consumer of the associative buffer's lookup result on the DE0 board. It counts hit events (rising edges of the buffer's data-valid output) in a saturating counter. It holds the most recent hit data. It drives four active-low seven-segment digits: hit data on HEX1:HEX0, hit count on HEX3:HEX2. A decimal-point blink on HEX0 acknowledges each new hit.

## Interface
Parameters:
- DATA_WIDTH, 8: width of the buffer's data output; only bits [7:0] are displayed.
- BLINK_CYCLES, 25_000_000: decimal-point on-time after a hit, in clk cycles (0.5 s at 50 MHz); must be ≥ 1.

Ports:
- clk  input  1  system clock, rising edge.
- async_reset  input  1  one clock; reset is synchronous and active-low. The name matches the rest of the design, but the input is sampled only on the rising clk edge.
- data_in  input  DATA_WIDTH  buffer data output.
- data_valid_in  input  1  buffer data-valid output (1 = lookup hit this cycle).
- clear_stats  input  1  synchronous clear of the counter, held data and blink; active-high, level.
- hit_count  output  8  current saturating hit count (registered).
- hex0  output  7  active-low segments {g,f,e,d,c,b,a}, held data [3:0].
- hex1  output  7  held data [7:4].
- hex2  output  7  hit_count [3:0].
- hex3  output  7  hit_count [7:4].
- hex_dp  output  4  active-low decimal points. Bit 0 is the blink; bits 3:1 are constant 1 (off).

## Operation
- Edge detect: valid_q registers data_valid_in every cycle. hit_event = data_valid_in & ~valid_q.
- The counter counts hit events, not hit cycles. A static key that keeps hitting counts once.
- Hit counter: 8-bit, +1 on hit_event, saturates at 8'hFF (no wrap).
- Held data: loads data_in[7:0] on every cycle with data_valid_in=1, so it tracks a live hit. It holds when data_valid_in=0.
- Blink timer: ceil(log2(BLINK_CYCLES+1)) bits.
  - Loads BLINK_CYCLES on hit_event; a new event during a blink reloads it.
  - Decrements while non-zero.
  - hex_dp[0] = 0 (lit) while the timer ≠ 0.
- Seven-segment decode, registered, hex glyphs 0–F. Required encodings:
  - 0 = 7'b1000000
  - 1 = 7'b1111001
  - 5 = 7'b0010010
  - A = 7'b0001000
  - F = 7'b0001110
- Priority per cycle: reset > clear_stats > hit_event / load.
  - clear_stats zeroes the counter, held data and blink timer.
  - valid_q still updates during clear_stats, so a valid level held across a clear is not counted afterwards.
- No FSM beyond the edge detector and blink timer. All state is in registers updated only on the rising clk edge.

## Timing
- Reset, async_reset=0 sampled at an edge:
  - hit_count=0, held data=0, valid_q=0, timer=0.
  - hex0..hex3 = 7'b1000000 ("0").
  - hex_dp = 4'b1111.
- hit_count and the timer load take effect at the edge sampling the hit_event (latency 1 cycle from the input).
- The hex outputs and hex_dp follow one edge later (2 cycles from the input).
- Blink length: hex_dp[0] is low for exactly BLINK_CYCLES consecutive cycles after an isolated event.
- A valid pulse lasting one cycle counts 1. A valid level held for N cycles counts 1. Valid high → low → high counts 2.
- Reset mid-blink: dp off 1 cycle after the reset edge. There is no residual count.
- data_valid_in high in the first cycle after reset counts as an event, because valid_q is 0.

## Test plan
- Reset for 2 cycles, then idle → hit_count=0, hex0..3=7'b1000000, hex_dp=4'b1111 throughout.
- data_in=8'hA5, single-cycle valid pulse (BLINK_CYCLES=4) → hit_count=1 after 1 edge; hex1=A, hex0=5, hex2=1 after 2 edges; hex_dp[0]=0 for exactly 4 cycles.
- valid held high 10 cycles, data_in changing 8'h01→8'h0F → hit_count=1; hex0 shows F, then data holds after valid falls.
- 300 separate valid pulses → hit_count saturates at 8'hFF; hex3=hex2=F.
- clear_stats asserted on the same cycle as a valid rising edge with hit_count=7 → hit_count=0, held data=0, dp off. The next cycle with valid still high → no count.
- Reset asserted mid-blink with hit_count=3 → all outputs return to reset values at the following edge.
